// File: rtl/uart_pkg.sv
// Shared UART link definitions: FSM state encodings and default link parameters.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    RX_START_BIT = 3'd1,
    RX_DATA_BITS = 3'd2,
    RX_STOP_BIT  = 3'd3,
    CLEANUP      = 3'd4
  } uart_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud
  localparam int DEFAULT_DATA_BITS    = 128;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for one async input; resets to 1 (idle line level).
// Latency: 2 i_clk cycles from input change to sync_out.
// Backpressure: none.
module uart_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q   <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta_q   <= async_in;
      sync_out <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start bit, DATA_BITS data bits LSB first, one stop bit, centre sampled.
// Latency: word valid about mid stop bit plus 2 cycles of synchroniser delay.
// Backpressure: none; o_rx_dv is a one-cycle pulse that must be captured on the spot.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx_serial,
  output logic                 o_rx_dv,
  output logic [DATA_BITS-1:0] o_rx_byte,
  output logic                 o_rx_active,
  output logic                 o_rx_frame_err
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [15:0]      HALF_CNT = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0]      FULL_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_t          state_q, state_d;
  logic [15:0]          clk_cnt_q, clk_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_byte_d;
  logic                 rx_dv_d, rx_active_d, frame_err_d;

  uart_sync2 u_sync (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .async_in (i_rx_serial),
    .sync_out (rx_s)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= IDLE;
      clk_cnt_q      <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      o_rx_byte      <= '0;
      o_rx_dv        <= 1'b0;
      o_rx_active    <= 1'b0;
      o_rx_frame_err <= 1'b0;
    end else begin
      state_q        <= state_d;
      clk_cnt_q      <= clk_cnt_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      o_rx_byte      <= rx_byte_d;
      o_rx_dv        <= rx_dv_d;
      o_rx_active    <= rx_active_d;
      o_rx_frame_err <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_byte_d   = o_rx_byte;
    rx_dv_d     = o_rx_dv;
    rx_active_d = o_rx_active;
    frame_err_d = o_rx_frame_err;

    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (!rx_s) begin
          state_d     = RX_START_BIT;
          rx_active_d = 1'b1;
        end
      end

      RX_START_BIT: begin
        if (clk_cnt_q == HALF_CNT) begin
          if (!rx_s) begin
            clk_cnt_d = '0;
            state_d   = RX_DATA_BITS;
          end else begin
            // Start bit gone by its centre: treat as a glitch and re-arm.
            rx_active_d = 1'b0;
            state_d     = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end

      RX_DATA_BITS: begin
        if (clk_cnt_q < FULL_CNT) begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end else begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q < LAST_IDX) begin
            bit_idx_d = bit_idx_q + 1'b1;
          end else begin
            bit_idx_d = '0;
            state_d   = RX_STOP_BIT;
          end
        end
      end

      RX_STOP_BIT: begin
        if (clk_cnt_q < FULL_CNT) begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end else begin
          clk_cnt_d = '0;
          if (rx_s) begin
            rx_byte_d = shift_q;
            rx_dv_d   = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          rx_active_d = 1'b0;
          state_d     = CLEANUP;
        end
      end

      CLEANUP: begin
        rx_dv_d     = 1'b0;
        frame_err_d = 1'b0;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bit-banged frames, scoreboard of expected word/error pulses.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int DB  = 128;

  typedef struct {
    logic          ferr;
    logic [DB-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic          o_rx_dv;
  logic [DB-1:0] o_rx_byte;
  logic          o_rx_active;
  logic          o_rx_frame_err;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [DB-1:0] last_good = '0;
  int   exp_dv = 0, exp_ferr = 0;
  int   dv_cnt = 0, ferr_cnt = 0;
  int   active_gap = 0, byte_changes = 0;
  logic saw_active = 1'b0;
  logic chk_active = 1'b0;
  logic prev_dv = 1'b0, prev_ferr = 1'b0;
  logic [DB-1:0] held_byte = '0;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_rx_serial    (rx),
    .o_rx_dv        (o_rx_dv),
    .o_rx_byte      (o_rx_byte),
    .o_rx_active    (o_rx_active),
    .o_rx_frame_err (o_rx_frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output pulse, tracks pulse shape and byte stability.
  always @(negedge clk) begin
    if (rst) begin
      held_byte = '0;
      prev_dv   = 1'b0;
      prev_ferr = 1'b0;
    end else begin
      if (o_rx_active) saw_active = 1'b1;
      if (chk_active && !o_rx_active) active_gap++;
      if (o_rx_dv) dv_cnt++;
      if (o_rx_frame_err) ferr_cnt++;
      if (o_rx_dv || o_rx_frame_err) begin
        check("pulse_exclusive", DB'(o_rx_dv & o_rx_frame_err), '0);
        check("pulse_one_cycle", DB'((o_rx_dv & prev_dv) | (o_rx_frame_err & prev_ferr)), '0);
        check("sb_pending", DB'(exp_q.size() != 0), DB'(1));
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("pulse_kind_ferr", DB'(o_rx_frame_err), DB'(e.ferr));
          check("rx_byte", o_rx_byte, e.data);
        end
      end
      if (o_rx_dv) held_byte = o_rx_byte;
      else if (o_rx_byte !== held_byte) byte_changes++;
      prev_dv   = o_rx_dv;
      prev_ferr = o_rx_frame_err;
    end
  end

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_word(input logic [DB-1:0] d);
    exp_q.push_back('{ferr: 1'b0, data: d});
    last_good = d;
    exp_dv++;
  endtask

  task automatic expect_ferr();
    exp_q.push_back('{ferr: 1'b1, data: last_good});
    exp_ferr++;
  endtask

  // Sends a frame; if abort_at < DB, stops half-way through that data bit.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input int abort_at);
    drive(1'b0, 4);
    chk_active = 1'b1;
    drive(1'b0, CPB - 4);
    for (int i = 0; i < DB; i++) begin
      if (i == abort_at) begin
        drive(d[i], CPB / 2);
        return;
      end
      drive(d[i], CPB);
    end
    drive(stop, 4);
    chk_active = 1'b0;
    drive(stop, CPB - 4);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check(tag, DB'(exp_q.size()), '0);
    check("active_gap", DB'(active_gap), '0);
  endtask

  initial begin
    // Reset and idle line
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    saw_active = 1'b0;
    drive(1'b1, 100);
    check("reset_dv", DB'(o_rx_dv), '0);
    check("reset_byte", o_rx_byte, '0);
    check("reset_active", DB'(o_rx_active), '0);
    check("reset_ferr", DB'(o_rx_frame_err), '0);
    check("idle_no_active", DB'(saw_active), '0);

    // Normal frame
    expect_word(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    send_frame(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1, DB);
    drive(1'b1, 10);
    wait_drain("drain_frame_a");

    // Start-bit glitch, then a real frame
    saw_active = 1'b0;
    drive(1'b0, 4);
    drive(1'b1, 40);
    check("glitch_saw_active", DB'(saw_active), DB'(1));
    check("glitch_active_low", DB'(o_rx_active), '0);
    check("glitch_no_dv", DB'(dv_cnt), DB'(exp_dv));
    expect_word(128'h1);
    send_frame(128'h1, 1'b1, DB);
    drive(1'b1, 10);
    wait_drain("drain_frame_one");

    // Framing error keeps the prior word
    expect_ferr();
    send_frame({8{16'hAAAA}}, 1'b0, DB);
    drive(1'b1, 40);
    wait_drain("drain_ferr");
    check("ferr_byte_kept", o_rx_byte, 128'h1);
    check("ferr_count", DB'(ferr_cnt), DB'(exp_ferr));

    // Back-to-back frames
    expect_word('0);
    expect_word('1);
    send_frame('0, 1'b1, DB);
    send_frame('1, 1'b1, DB);
    drive(1'b1, 10);
    wait_drain("drain_b2b");
    check("b2b_byte", o_rx_byte, '1);

    // Reset mid-frame at data bit 60
    send_frame(128'h5555_0000_FFFF_1234_5555_0000_FFFF_1234, 1'b1, 60);
    chk_active = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_active", DB'(o_rx_active), '0);
    check("midrst_byte", o_rx_byte, '0);
    rst = 1'b0;
    last_good = '0;
    drive(1'b1, 2200);
    check("midrst_no_dv", DB'(dv_cnt), DB'(exp_dv));
    check("midrst_no_ferr", DB'(ferr_cnt), DB'(exp_ferr));
    expect_word(128'hDEAD_BEEF);
    send_frame(128'hDEAD_BEEF, 1'b1, DB);
    drive(1'b1, 10);
    wait_drain("drain_deadbeef");

    check("total_dv", DB'(dv_cnt), DB'(exp_dv));
    check("total_ferr", DB'(ferr_cnt), DB'(exp_ferr));
    check("byte_stable", DB'(byte_changes), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
